// File: rtl/execute_writeback.sv
// Execute/writeback back end: EX/MEM register (ALU, branch target, memory op) feeding a MEM/WB register.
// Optional operand forwarding and load-use stall are enabled by defining WB_BYPASS_EN.
module execute_writeback (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] reg1_data,
    input  logic [31:0] reg2_data,
    input  logic [63:0] immediate,
    input  logic [31:0] cnt_val_pl4_in,
    input  logic [3:0]  alu_op,
    input  logic        alu_src,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic        write_back,
    input  logic        reg_write_in,
    input  logic        branch_in,
    input  logic [4:0]  rd_in,
    input  logic [4:0]  rs1_in,
    input  logic [4:0]  rs2_in,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic [4:0]  wr_reg,
    output logic        reg_write,
    output logic [31:0] write_back_data,
    output logic        branch_ctr,
    output logic [31:0] cnt_out
);

    typedef struct packed {
        logic        vld;
        logic [31:0] res;
        logic [31:0] sdata;
        logic        mem_rd;
        logic        mem_wr;
        logic        wb_sel;
        logic        rw;
        logic [4:0]  rd;
        logic        br;
        logic [31:0] tgt;
    } exmem_t;

    typedef struct packed {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] data;
    } memwb_t;

    typedef enum logic {IDLE, MEM_WAIT} state_e;

    exmem_t ex_q, ex_d;
    memwb_t wb_q, wb_d;
    state_e state_q, state_d;
    logic [31:0] cnt_q, cnt_d;

    logic [31:0] rs1_val, rs2_val, op_b, diff, alu_res, target;
    logic        zero, load_hazard, mem_busy, mem_wait, accept;
    logic        unused_in;

    assign unused_in = ^{immediate[63:32], rs1_in, rs2_in};

    always_comb begin
        rs1_val     = reg1_data;
        rs2_val     = reg2_data;
        load_hazard = 1'b0;
`ifdef WB_BYPASS_EN
        // EX/MEM is checked last so a younger non-load result overrides MEM/WB.
        if (wb_q.rw && wb_q.rd == rs1_in) rs1_val = wb_q.data;
        if (wb_q.rw && wb_q.rd == rs2_in) rs2_val = wb_q.data;
        if (ex_q.vld && ex_q.rw && !ex_q.mem_rd && !ex_q.wb_sel) begin
            if (ex_q.rd == rs1_in) rs1_val = ex_q.res;
            if (ex_q.rd == rs2_in) rs2_val = ex_q.res;
        end
        load_hazard = in_valid && ex_q.vld && ex_q.rw && (ex_q.mem_rd || ex_q.wb_sel) &&
                      (ex_q.rd == rs1_in || ex_q.rd == rs2_in);
`endif
    end

    always_comb begin
        op_b   = alu_src ? immediate[31:0] : rs2_val;
        diff   = rs1_val - op_b;
        zero   = (diff == 32'd0);
        target = (cnt_val_pl4_in - 32'd4) + (immediate[31:0] << 1);
        case (alu_op)
            4'b0000: alu_res = rs1_val & op_b;
            4'b0001: alu_res = rs1_val | op_b;
            4'b0010: alu_res = rs1_val + op_b;
            4'b0110: alu_res = diff;
            4'b0111: alu_res = {31'd0, $signed(rs1_val) < $signed(op_b)};
            4'b1100: alu_res = ~(rs1_val | op_b);
            default: alu_res = 32'd0;
        endcase
    end

    assign mem_busy = ex_q.vld && (ex_q.mem_rd || ex_q.mem_wr);
    assign mem_wait = mem_busy && !dmem_ready;
    assign stall    = mem_wait || load_hazard;
    assign accept   = in_valid && !stall;

    always_comb begin
        ex_d = '0;
        if (mem_wait) begin
            ex_d = ex_q;
        end else if (accept) begin
            ex_d.vld    = 1'b1;
            ex_d.res    = alu_res;
            ex_d.sdata  = rs2_val;
            ex_d.mem_rd = mem_rd;
            ex_d.mem_wr = mem_wr;
            ex_d.wb_sel = write_back;
            ex_d.rw     = reg_write_in && (rd_in != 5'd0) && !mem_wr && !branch_in;
            ex_d.rd     = rd_in;
            ex_d.br     = branch_in && zero && !mem_rd && !mem_wr;
            ex_d.tgt    = target;
        end
    end

    // A waiting memory op leaves EX/MEM in place and sends a bubble down.
    always_comb begin
        wb_d = '0;
        if (ex_q.vld && !mem_wait) begin
            wb_d.rw   = ex_q.rw;
            wb_d.rd   = ex_q.rd;
            wb_d.data = ex_q.wb_sel ? dmem_rdata : ex_q.res;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (mem_wait) state_d = MEM_WAIT;
            MEM_WAIT: if (dmem_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    assign branch_ctr = ex_q.vld && ex_q.br;
    assign cnt_out    = branch_ctr ? ex_q.tgt : cnt_q;
    assign cnt_d      = cnt_out;

    assign dmem_req        = mem_busy;
    assign dmem_we         = mem_busy && ex_q.mem_wr;
    assign dmem_addr       = mem_busy ? ex_q.res : 32'd0;
    assign dmem_wdata      = mem_busy ? ex_q.sdata : 32'd0;
    assign wr_reg          = wb_q.rd;
    assign reg_write       = wb_q.rw;
    assign write_back_data = wb_q.data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q    <= '0;
            wb_q    <= '0;
            state_q <= IDLE;
            cnt_q   <= 32'd0;
        end else begin
            ex_q    <= ex_d;
            wb_q    <= wb_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_execute_writeback.sv
// Directed and randomized checks of execute_writeback against a behavioural model.
module tb_execute_writeback;

    logic        clk, rst, in_valid;
    logic [31:0] reg1_data, reg2_data, cnt_val_pl4_in;
    logic [63:0] immediate;
    logic [3:0]  alu_op;
    logic        alu_src, mem_rd, mem_wr, write_back, reg_write_in, branch_in;
    logic [4:0]  rd_in, rs1_in, rs2_in;
    logic        stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ready;
    logic [4:0]  wr_reg;
    logic        reg_write;
    logic [31:0] write_back_data;
    logic        branch_ctr;
    logic [31:0] cnt_out;

    int checks = 0;
    int errors = 0;

    execute_writeback dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .reg1_data(reg1_data), .reg2_data(reg2_data), .immediate(immediate),
        .cnt_val_pl4_in(cnt_val_pl4_in), .alu_op(alu_op), .alu_src(alu_src),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .write_back(write_back),
        .reg_write_in(reg_write_in), .branch_in(branch_in),
        .rd_in(rd_in), .rs1_in(rs1_in), .rs2_in(rs2_in),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ready(dmem_ready), .wr_reg(wr_reg), .reg_write(reg_write),
        .write_back_data(write_back_data), .branch_ctr(branch_ctr), .cnt_out(cnt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        in_valid = 0; reg1_data = 0; reg2_data = 0; immediate = 0; cnt_val_pl4_in = 0;
        alu_op = 0; alu_src = 0; mem_rd = 0; mem_wr = 0; write_back = 0;
        reg_write_in = 0; branch_in = 0; rd_in = 0; rs1_in = 0; rs2_in = 0;
    endtask

    task automatic issue_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd);
        clr();
        in_valid = 1; alu_op = op; reg1_data = a; reg2_data = b;
        reg_write_in = 1; rd_in = rd;
    endtask

    task automatic run_alu(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
        issue_alu(op, a, b, rd);
        tick();
        clr();
        tick();
        chk({tag, "_rw"}, reg_write, 1);
        chk({tag, "_rd"}, wr_reg, rd);
        chk({tag, "_data"}, write_back_data, exp);
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd6:    return a - b;
            4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd12:   return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    logic [3:0]  ops [8];
    logic [31:0] opb, cur_tgt, cur_data, last_tgt, prev_data;
    logic [4:0]  prev_rd;
    logic        cur_br, cur_rw, prev_rw;

    initial begin
        ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd3, 4'd15};
        rst = 0; dmem_ready = 0; dmem_rdata = 0;
        clr();
        #12;
        chk("rst_stall", stall, 0);
        chk("rst_req", dmem_req, 0);
        chk("rst_rw", reg_write, 0);
        chk("rst_wbd", write_back_data, 0);
        chk("rst_brctr", branch_ctr, 0);
        chk("rst_cnt", cnt_out, 0);
        rst = 1;
        dmem_ready = 1;

        run_alu("add", 4'b0010, 32'd5, 32'd7, 5'd3, 32'd12);
        run_alu("sub", 4'b0110, 32'd3, 32'd5, 5'd4, 32'hFFFF_FFFE);
        run_alu("slt", 4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd6, 32'd1);
        run_alu("bad_op", 4'b1111, 32'h1234, 32'h5678, 5'd8, 32'd0);
        run_alu("nor", 4'b1100, 32'h0F0F_0000, 32'h0000_00FF, 5'd9, 32'hF0F0_FF00);

        // taken beq
        clr();
        in_valid = 1; branch_in = 1; alu_op = 4'b0110; reg1_data = 9; reg2_data = 9;
        cnt_val_pl4_in = 32'h104; immediate = 64'd8;
        tick();
        chk("beq_brctr", branch_ctr, 1);
        chk("beq_cnt", cnt_out, 32'h110);
        clr();
        tick();
        chk("beq_brctr_drop", branch_ctr, 0);
        chk("beq_cnt_hold", cnt_out, 32'h110);
        chk("beq_no_write", reg_write, 0);
        // not-taken beq
        in_valid = 1; branch_in = 1; alu_op = 4'b0110; reg1_data = 1; reg2_data = 2;
        cnt_val_pl4_in = 32'h200; immediate = 64'd4;
        tick();
        chk("bne_brctr", branch_ctr, 0);
        chk("bne_cnt_hold", cnt_out, 32'h110);

        // load with three wait cycles, next bundle held upstream meanwhile
        dmem_ready = 0;
        clr();
        in_valid = 1; alu_op = 4'b0010; alu_src = 1; reg1_data = 32'h10; immediate = 64'h10;
        mem_rd = 1; write_back = 1; reg_write_in = 1; rd_in = 5'd5;
        tick();
        issue_alu(4'b0010, 32'd1, 32'd1, 5'd7);
        for (int c = 0; c < 3; c++) begin
            chk("ld_stall", stall, 1);
            chk("ld_req", dmem_req, 1);
            chk("ld_we", dmem_we, 0);
            chk("ld_addr", dmem_addr, 32'h20);
            if (c > 0) chk("ld_bubble", reg_write, 0);
            tick();
        end
        dmem_ready = 1; dmem_rdata = 32'hCAFE_F00D;
        #1;
        chk("ld_release", stall, 0);
        tick();
        clr();
        chk("ld_rw", reg_write, 1);
        chk("ld_rd", wr_reg, 5);
        chk("ld_data", write_back_data, 32'hCAFE_F00D);
        tick();
        chk("held_rd", wr_reg, 7);
        chk("held_data", write_back_data, 2);

        // zero-wait store
        clr();
        in_valid = 1; alu_op = 4'b0010; alu_src = 1; reg1_data = 32'h100; immediate = 64'd4;
        reg2_data = 32'hDEAD; mem_wr = 1; reg_write_in = 1; rd_in = 5'd10;
        tick();
        clr();
        chk("st_req", dmem_req, 1);
        chk("st_we", dmem_we, 1);
        chk("st_addr", dmem_addr, 32'h104);
        chk("st_wdata", dmem_wdata, 32'hDEAD);
        chk("st_stall", stall, 0);
        tick();
        chk("st_no_write", reg_write, 0);

`ifdef WB_BYPASS_EN
        issue_alu(4'b0010, 32'd2, 32'd3, 5'd1);
        tick();
        clr();
        in_valid = 1; alu_op = 4'b0010; rs1_in = 5'd1; reg1_data = 0; alu_src = 1;
        immediate = 64'd1; reg_write_in = 1; rd_in = 5'd2;
        tick();
        clr();
        tick();
        chk("byp_rd", wr_reg, 2);
        chk("byp_data", write_back_data, 6);
`endif

        // reset during a memory wait
        dmem_ready = 0;
        clr();
        in_valid = 1; alu_op = 4'b0010; alu_src = 1; immediate = 64'h40;
        mem_rd = 1; write_back = 1; reg_write_in = 1; rd_in = 5'd5;
        tick();
        clr();
        chk("rstw_req_before", dmem_req, 1);
        #2 rst = 0;
        #1;
        chk("rstw_req", dmem_req, 0);
        chk("rstw_stall", stall, 0);
        chk("rstw_cnt", cnt_out, 0);
        chk("rstw_rw", reg_write, 0);
        #2 rst = 1;
        tick();
        chk("rstw_idle_req", dmem_req, 0);
        chk("rstw_idle_stall", stall, 0);

        // randomized ALU / branch traffic, no memory ops
        dmem_ready = 1;
        last_tgt = 0; prev_rw = 0; prev_rd = 0; prev_data = 0;
        for (int i = 0; i < 300; i++) begin
            clr();
            in_valid       = ($urandom_range(0, 3) != 0);
            alu_op         = ops[$urandom_range(0, 7)];
            reg1_data      = $urandom;
            reg2_data      = ($urandom_range(0, 3) == 0) ? reg1_data : $urandom;
            alu_src        = $urandom_range(0, 1);
            immediate      = {$urandom, $urandom};
            if (alu_src && $urandom_range(0, 3) == 0) immediate[31:0] = reg1_data;
            branch_in      = ($urandom_range(0, 2) == 0);
            reg_write_in   = $urandom_range(0, 1);
            rd_in          = $urandom;
            cnt_val_pl4_in = $urandom;
            opb      = alu_src ? immediate[31:0] : reg2_data;
            cur_br   = in_valid && branch_in && (reg1_data == opb);
            cur_tgt  = cnt_val_pl4_in - 4 + 2 * immediate[31:0];
            cur_rw   = in_valid && reg_write_in && (rd_in != 0) && !branch_in;
            cur_data = alu_ref(alu_op, reg1_data, opb);
            chk("rnd_stall", stall, 0);
            tick();
            chk("rnd_brctr", branch_ctr, cur_br);
            if (cur_br) last_tgt = cur_tgt;
            chk("rnd_cnt", cnt_out, last_tgt);
            chk("rnd_rw", reg_write, prev_rw);
            if (prev_rw) begin
                chk("rnd_rd", wr_reg, prev_rd);
                chk("rnd_data", write_back_data, prev_data);
            end
            prev_rw = cur_rw; prev_rd = rd_in; prev_data = cur_data;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/execute_writeback.md
EXECUTE_WRITEBACK -- requirements
Module: execute_writeback

Interface
REQ-001 SHALL have these ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have these ports: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have these ports: in_valid  in  1  decode bundle valid; reg1_data, reg2_data  in  32  operands; immediate  in  64  sign-extended immediate; cnt_val_pl4_in  in  32  PC+4 of instruction.
REQ-004 SHALL have these ports: alu_op  in  4  ALU select; alu_src  in  1  operand-B select (1=immediate); mem_rd, mem_wr  in  1  load/store; write_back  in  1  result from memory (1) or ALU (0); reg_write_in  in  1  writes rd; branch_in  in  1  conditional branch (beq); rd_in, rs1_in, rs2_in  in  5  register indices.
REQ-005 SHALL have these ports: stall  out  1  bundle not accepted this cycle; dmem_req, dmem_we  out  1; dmem_addr, dmem_wdata  out  32; dmem_rdata  in  32; dmem_ready  in  1.
REQ-006 SHALL have these ports: wr_reg  out  5; reg_write  out  1; write_back_data  out  32; branch_ctr  out  1  branch-taken pulse; cnt_out  out  32  branch target.

Function
REQ-007 SHALL be a two-register pipeline: EX/MEM register (ALU result, store data, controls, target) then MEM/WB register (wr_reg, reg_write, write_back_data).
REQ-008 SHALL accept a bundle when in_valid=1 and stall=0; ALU result enters EX/MEM on the next edge; reg_write/write_back_data appear two cycles after acceptance when memory completes without wait.
REQ-009 SHALL take operand B = alu_src ? immediate[31:0] : reg2_data (immediate[63:32] ignored).
REQ-010 SHALL decode alu_op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 0/1), 1100 NOR, any other code yields 0; arithmetic wraps modulo 2^32.
REQ-011 SHALL set zero when A-B==0; branch taken when branch_in && zero && valid.
REQ-012 SHALL compute target = (cnt_val_pl4_in - 4) + (immediate[31:0] << 1), modulo 2^32.
REQ-013 SHALL drive branch_ctr=1 for exactly one cycle while the taken branch occupies EX/MEM, with cnt_out = target; cnt_out holds its last value otherwise.
REQ-014 SHALL use FSM states IDLE and MEM_WAIT; IDLE->MEM_WAIT when valid EX/MEM holds mem_rd or mem_wr and dmem_ready=0; MEM_WAIT->IDLE on dmem_ready=1.
REQ-015 SHALL drive dmem_req=1 combinationally while a valid memory op sits in EX/MEM, with dmem_we=mem_wr, dmem_addr=ALU result, dmem_wdata=store operand, all stable until dmem_ready.
REQ-016 SHALL hold stall=1 and freeze EX/MEM while a memory op waits; MEM/WB receives a bubble (reg_write=0) each wait cycle.
REQ-017 SHALL complete a memory op in the cycle dmem_ready=1 (zero wait when ready is already high); dmem_ready without dmem_req is ignored.
REQ-018 SHALL select write_back_data = write_back ? dmem_rdata (captured) : ALU result.
REQ-019 SHALL force reg_write=0 when rd_in==0 or the slot is a bubble; stores and branches never write.
REQ-020 SHALL treat in_valid=1 while stall=1 as not accepted; upstream holds the bundle.

Reset
REQ-021 SHALL, while rst=0, asynchronously clear both pipeline registers and the FSM (IDLE); all outputs read 0.
REQ-022 SHALL drop dmem_req immediately when rst asserts mid-transaction; the op is discarded, not replayed.

Configuration
REQ-023 SHALL, with WB_BYPASS_EN defined, forward operands: an EX/MEM non-load result has priority over MEM/WB, matching on rs1_in/rs2_in == rd with reg_write and rd!=0.
REQ-024 SHALL, with WB_BYPASS_EN defined, assert stall for one cycle when a load in EX/MEM targets rs1_in or rs2_in, then forward from MEM/WB.
REQ-025 SHALL, without WB_BYPASS_EN, use reg1_data/reg2_data unmodified, ignore rs1_in/rs2_in, and never stall for hazards.

Verification
REQ-026 SHALL cover: ADD reg1=5, reg2=7, rd=3 -> two cycles later wr_reg=3, reg_write=1, write_back_data=12.
REQ-027 SHALL cover: SUB 3-5 -> 0xFFFFFFFE; SLT -1,1 -> 1; alu_op=1111 -> 0.
REQ-028 SHALL cover: beq reg1=reg2=9, cnt_val_pl4_in=0x104, imm=8 -> one-cycle branch_ctr, cnt_out=0x110.
REQ-029 SHALL cover: load addr 0x20, dmem_ready low 3 cycles -> stall=1 for 3 cycles, dmem_addr stable at 0x20, then write_back_data=dmem_rdata.
REQ-030 SHALL cover: rst low during MEM_WAIT -> dmem_req=0 and outputs 0 immediately, IDLE after release.
REQ-031 SHALL cover, with WB_BYPASS_EN defined: ADD x1=2+3 followed by ADD x2=x1+1 with stale reg1=0 -> x2 result 6.
